// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: opcodes, instruction field
// positions, default widths and a small opcode classifier.
package cpu16_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADR_W  = 3;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_LW   = 4'd2;
    localparam logic [3:0] OP_SW   = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_J    = 4'd5;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RS_MSB  = 11;
    localparam int RS_LSB  = 9;
    localparam int RT_MSB  = 8;
    localparam int RT_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int FN_MSB  = 2;
    localparam int FN_LSB  = 0;
    localparam int IMM_MSB = 5;
    localparam int IMM_LSB = 0;
    localparam int JT_MSB  = 11;

    // Per-opcode control summary; anything unrecognised decodes as a NOP.
    typedef struct packed {
        logic use_rs;
        logic use_rt;
        logic wen;
        logic dst_rt;
        logic is_load;
        logic is_store;
    } dec_t;

    function automatic dec_t decode_op(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            OP_R: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
                d.wen    = 1'b1;
            end
            OP_ADDI: begin
                d.use_rs = 1'b1;
                d.wen    = 1'b1;
                d.dst_rt = 1'b1;
            end
            OP_LW: begin
                d.use_rs  = 1'b1;
                d.wen     = 1'b1;
                d.dst_rt  = 1'b1;
                d.is_load = 1'b1;
            end
            OP_SW: begin
                d.use_rs   = 1'b1;
                d.use_rt   = 1'b1;
                d.is_store = 1'b1;
            end
            OP_BEQ: begin
                d.use_rs = 1'b1;
                d.use_rt = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_hazard.sv
// Operand forwarding muxes for both sources plus load-use detection.
// Purely combinational.
module id_fwd_hazard
    import cpu16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADR_W  = DEF_ADR_W
) (
    input  logic              if_valid,
    input  logic [ADR_W-1:0]  rs,
    input  logic [ADR_W-1:0]  rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic              exf_valid,
    input  logic [ADR_W-1:0]  exf_adr,
    input  logic [DATA_W-1:0] exf_data,
    input  logic              exf_is_load,
    input  logic              wb_wen,
    input  logic [ADR_W-1:0]  wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    output logic              hazard
);

    logic ex_fwd_ok;
    assign ex_fwd_ok = exf_valid && !exf_is_load;

    // rs operand: EX result beats the WB write, which beats the register file
    // (the file only commits the WB write on the following edge).
    always_comb begin
        opnd_a = rf_data1;
        if (ex_fwd_ok && (exf_adr == rs))
            opnd_a = exf_data;
        else if (wb_wen && (wb_adr == rs))
            opnd_a = wb_data;
    end

    // rt operand, same priority as rs.
    always_comb begin
        opnd_b = rf_data2;
        if (ex_fwd_ok && (exf_adr == rt))
            opnd_b = exf_data;
        else if (wb_wen && (wb_adr == rt))
            opnd_b = wb_data;
    end

    // A load in EX cannot forward yet; only sources the instruction really reads count.
    assign hazard = if_valid && exf_valid && exf_is_load &&
                    ((use_rs && (exf_adr == rs)) || (use_rt && (exf_adr == rt)));

endmodule

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: decodes the fetched word, drives the
// register-file read ports, resolves operands and loads the ID/EX register.
module id_operand_stage
    import cpu16_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADR_W  = DEF_ADR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic [15:0]       if_pc,
    output logic              if_ready,
    output logic [ADR_W-1:0]  rf_read_adr1,
    output logic [ADR_W-1:0]  rf_read_adr2,
    input  logic [DATA_W-1:0] rf_readdata1,
    input  logic [DATA_W-1:0] rf_readdata2,
    input  logic              exf_valid,
    input  logic [ADR_W-1:0]  exf_adr,
    input  logic [DATA_W-1:0] exf_data,
    input  logic              exf_is_load,
    input  logic              wb_wen,
    input  logic [ADR_W-1:0]  wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [2:0]        ex_funct,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADR_W-1:0]  ex_rd,
    output logic              ex_wen,
    output logic              ex_is_load,
    output logic              ex_is_store,
    output logic [15:0]       ex_pc,
    output logic              hazard_stall
);

    logic [3:0]        op;
    logic [ADR_W-1:0]  rs;
    logic [ADR_W-1:0]  rt;
    logic [ADR_W-1:0]  rd;
    logic [2:0]        funct;
    dec_t              dec;
    logic [DATA_W-1:0] imm;
    logic [ADR_W-1:0]  dst;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic              hazard;

    assign op    = if_instr[OP_MSB:OP_LSB];
    assign rs    = if_instr[RS_MSB:RS_LSB];
    assign rt    = if_instr[RT_MSB:RT_LSB];
    assign rd    = if_instr[RD_MSB:RD_LSB];
    assign funct = if_instr[FN_MSB:FN_LSB];
    assign dec   = decode_op(op);

    assign rf_read_adr1 = rs;
    assign rf_read_adr2 = rt;

    // Jump targets are zero-extended 12-bit fields; everything else sign-extends imm6.
    always_comb begin
        imm = {{(DATA_W-6){if_instr[IMM_MSB]}}, if_instr[IMM_MSB:IMM_LSB]};
        if (op == OP_J)
            imm = {{(DATA_W-12){1'b0}}, if_instr[JT_MSB:0]};
    end

    // Non-writing instructions carry destination 0 so EX sees a clean field.
    always_comb begin
        dst = '0;
        if (dec.wen)
            dst = dec.dst_rt ? rt : rd;
    end

    id_fwd_hazard #(
        .DATA_W (DATA_W),
        .ADR_W  (ADR_W)
    ) u_fwd (
        .if_valid    (if_valid),
        .rs          (rs),
        .rt          (rt),
        .use_rs      (dec.use_rs),
        .use_rt      (dec.use_rt),
        .rf_data1    (rf_readdata1),
        .rf_data2    (rf_readdata2),
        .exf_valid   (exf_valid),
        .exf_adr     (exf_adr),
        .exf_data    (exf_data),
        .exf_is_load (exf_is_load),
        .wb_wen      (wb_wen),
        .wb_adr      (wb_adr),
        .wb_data     (wb_data),
        .opnd_a      (opnd_a),
        .opnd_b      (opnd_b),
        .hazard      (hazard)
    );

    assign if_ready     = !ex_stall && !hazard;
    assign hazard_stall = hazard && !rst;

    // ID/EX register: flush > stall (hold) > load-use bubble > capture > empty.
    // Bubbles also clear the side-effect flags so a stray valid bit cannot write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_a        <= '0;
            ex_b        <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
            ex_pc       <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
        end else if (ex_stall) begin
            ex_valid    <= ex_valid;
        end else if (hazard || !if_valid) begin
            ex_valid    <= 1'b0;
            ex_wen      <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_is_store <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_opcode   <= op;
            ex_funct    <= funct;
            ex_a        <= opnd_a;
            ex_b        <= opnd_b;
            ex_imm      <= imm;
            ex_rd       <= dst;
            ex_wen      <= dec.wen;
            ex_is_load  <= dec.is_load;
            ex_is_store <= dec.is_store;
            ex_pc       <= if_pc;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, checked through an expected-result queue.
module tb_id_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = '0;
    logic [15:0] if_pc = '0;
    logic        if_ready;
    logic [2:0]  rf_read_adr1;
    logic [2:0]  rf_read_adr2;
    logic [15:0] rf_readdata1;
    logic [15:0] rf_readdata2;
    logic        exf_valid = 1'b0;
    logic [2:0]  exf_adr = '0;
    logic [15:0] exf_data = '0;
    logic        exf_is_load = 1'b0;
    logic        wb_wen = 1'b0;
    logic [2:0]  wb_adr = '0;
    logic [15:0] wb_data = '0;
    logic        ex_stall = 1'b0;
    logic        flush = 1'b0;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [2:0]  ex_funct;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] ex_imm;
    logic [2:0]  ex_rd;
    logic        ex_wen;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [15:0] ex_pc;
    logic        hazard_stall;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  fn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic [15:0] pc;
        logic [2:0]  rd;
        logic        wen;
        logic        ld;
        logic        st;
        logic        ua;
        logic        ub;
    } exp_t;

    exp_t q[$];
    logic exp_valid = 1'b0;

    // Register file model: combinational read, write commits on the edge.
    logic [15:0] regs [8] = '{default: 16'h0000};
    assign rf_readdata1 = regs[rf_read_adr1];
    assign rf_readdata2 = regs[rf_read_adr2];
    always @(posedge clk) if (wb_wen) regs[wb_adr] <= wb_data;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_ready     (if_ready),
        .rf_read_adr1 (rf_read_adr1),
        .rf_read_adr2 (rf_read_adr2),
        .rf_readdata1 (rf_readdata1),
        .rf_readdata2 (rf_readdata2),
        .exf_valid    (exf_valid),
        .exf_adr      (exf_adr),
        .exf_data     (exf_data),
        .exf_is_load  (exf_is_load),
        .wb_wen       (wb_wen),
        .wb_adr       (wb_adr),
        .wb_data      (wb_data),
        .ex_stall     (ex_stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_opcode    (ex_opcode),
        .ex_funct     (ex_funct),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_imm       (ex_imm),
        .ex_rd        (ex_rd),
        .ex_wen       (ex_wen),
        .ex_is_load   (ex_is_load),
        .ex_is_store  (ex_is_store),
        .ex_pc        (ex_pc),
        .hazard_stall (hazard_stall)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand value as the instruction should see it at the issue cycle.
    function automatic logic [15:0] resolve(input logic [2:0] r);
        if (exf_valid && !exf_is_load && exf_adr == r) return exf_data;
        if (wb_wen && wb_adr == r) return wb_data;
        return regs[r];
    endfunction

    function automatic exp_t model(input logic [15:0] w, input logic [15:0] pc);
        exp_t e;
        int   v;
        logic [2:0] rs, rt, rd;
        rs = w[11:9];
        rt = w[8:6];
        rd = w[5:3];
        e.op = w[15:12];
        e.fn = w[2:0];
        e.pc = pc;
        e.ua = 1'b0; e.ub = 1'b0; e.wen = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.rd = 3'd0;
        case (int'(e.op))
            0: begin e.ua = 1; e.ub = 1; e.wen = 1; e.rd = rd; end
            1: begin e.ua = 1; e.wen = 1; e.rd = rt; end
            2: begin e.ua = 1; e.wen = 1; e.rd = rt; e.ld = 1; end
            3: begin e.ua = 1; e.ub = 1; e.st = 1; end
            4: begin e.ua = 1; e.ub = 1; end
            default: ;
        endcase
        if (int'(e.op) == 5) begin
            e.imm = w & 16'h0FFF;
        end else begin
            v = int'(w[5:0]);
            if (v >= 32) v = v - 64;
            e.imm = 16'(v);
        end
        e.a = resolve(rs);
        e.b = resolve(rt);
        return e;
    endfunction

    // Reference model: checks combinational outputs and predicts the next ID/EX content.
    always @(negedge clk) begin
        exp_t e;
        logic hz;
        if (rst) begin
            exp_valid = 1'b0;
            q.delete();
            chk("reset_ex_valid", ex_valid, 0);
            chk("reset_hazard_stall", hazard_stall, 0);
        end else begin
            e  = model(if_instr, if_pc);
            hz = if_valid && exf_valid && exf_is_load &&
                 ((e.ua && exf_adr == if_instr[11:9]) || (e.ub && exf_adr == if_instr[8:6]));
            chk("ex_valid", ex_valid, exp_valid);
            chk("hazard_stall", hazard_stall, hz);
            chk("if_ready", if_ready, !ex_stall && !hz);
            chk("rf_read_adr1", rf_read_adr1, if_instr[11:9]);
            chk("rf_read_adr2", rf_read_adr2, if_instr[8:6]);
            if (flush)           exp_valid = 1'b0;
            else if (ex_stall)   exp_valid = exp_valid;
            else if (hz)         exp_valid = 1'b0;
            else if (if_valid) begin
                exp_valid = 1'b1;
                q.push_back(e);
            end else             exp_valid = 1'b0;
        end
    end

    // Monitor: an entry is compared when it leaves ID/EX (consumed or flushed).
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_valid && (!ex_stall || flush)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: ex_valid=1 with pc %0h, no entry expected", ex_pc);
            end else begin
                e = q.pop_front();
                chk("ex_opcode", ex_opcode, e.op);
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_wen", ex_wen, e.wen);
                chk("ex_is_load", ex_is_load, e.ld);
                chk("ex_is_store", ex_is_store, e.st);
                if (e.wen) chk("ex_rd", ex_rd, e.rd);
                if (e.op == 4'd0) chk("ex_funct", ex_funct, e.fn);
                if (e.ua) chk("ex_a", ex_a, e.a);
                if (e.ub) chk("ex_b", ex_b, e.b);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_valid = 0; exf_valid = 0; exf_is_load = 0;
        wb_wen = 0; ex_stall = 0; flush = 0;
    endtask

    initial begin
        #3;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_pc", ex_pc, 0);
        #9 rst = 0;
        step();

        // R1 = 8 via write-back, then ADD R2 = R1 + R1 with no forwarding.
        wb_wen = 1; wb_adr = 3'd1; wb_data = 16'h0008;
        step();
        idle();
        if_valid = 1; if_instr = 16'h0250; if_pc = 16'h0010;
        step();
        chk("t1_ex_a", ex_a, 16'h0008);
        chk("t1_ex_b", ex_b, 16'h0008);
        chk("t1_ex_rd", ex_rd, 3'd2);
        chk("t1_ex_wen", ex_wen, 1);

        // EX forward beats WB forward on the same register.
        if_instr = 16'h0228; if_pc = 16'h0012;
        exf_valid = 1; exf_adr = 3'd1; exf_data = 16'h1234;
        wb_wen = 1; wb_adr = 3'd1; wb_data = 16'h5555;
        step();
        chk("t2_ex_a", ex_a, 16'h1234);

        // WB forward while the register file still holds the old value.
        idle();
        if_valid = 1; if_instr = 16'h00E0; if_pc = 16'h0014;
        wb_wen = 1; wb_adr = 3'd3; wb_data = 16'hBEEF;
        step();
        chk("t3_ex_b", ex_b, 16'hBEEF);

        // Load-use: SW reading R2 while LW to R2 is in EX.
        idle();
        exf_valid = 1; exf_is_load = 1; exf_adr = 3'd2;
        if_valid = 1; if_instr = 16'h3400; if_pc = 16'h0040;
        #1;
        chk("t4_if_ready", if_ready, 0);
        chk("t4_hazard_stall", hazard_stall, 1);
        step();
        chk("t4_bubble", ex_valid, 0);
        exf_valid = 0; exf_is_load = 0;
        #1;
        chk("t4_if_ready_release", if_ready, 1);
        step();
        chk("t4_accept", ex_valid, 1);
        chk("t4_store", ex_is_store, 1);

        // Immediate forms.
        if_instr = 16'h107E; if_pc = 16'h0050;
        step();
        chk("t5_addi_imm", ex_imm, 16'hFFFE);
        if_instr = 16'h5ABC; if_pc = 16'h0052;
        step();
        chk("t5_j_imm", ex_imm, 16'h0ABC);
        chk("t5_j_wen", ex_wen, 0);

        // Flush wins over stall.
        if_valid = 0; ex_stall = 1; flush = 1;
        step();
        chk("t6_flush_stall", ex_valid, 0);

        // Reset arriving mid-stall clears ID/EX without a clock edge.
        idle();
        if_valid = 1; if_instr = 16'h107E; if_pc = 16'h0060;
        step();
        ex_stall = 1;
        exf_valid = 1; exf_is_load = 1; exf_adr = 3'd0;
        step();
        chk("t6_held_valid", ex_valid, 1);
        chk("t6_held_imm", ex_imm, 16'hFFFE);
        #2 rst = 1;
        #1;
        chk("t6_rst_ex_valid", ex_valid, 0);
        chk("t6_rst_ex_imm", ex_imm, 0);
        chk("t6_rst_ex_pc", ex_pc, 0);
        chk("t6_rst_ex_opcode", ex_opcode, 0);
        chk("t6_rst_ex_wen", ex_wen, 0);
        chk("t6_rst_hazard_stall", hazard_stall, 0);
        step();
        rst = 0;
        idle();
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            if_valid    = ($urandom_range(0, 3) != 0);
            if_instr    = {4'($urandom_range(0, 7)), 12'($urandom)};
            if_pc       = 16'($urandom);
            exf_valid   = ($urandom_range(0, 1) == 1);
            exf_adr     = 3'($urandom);
            exf_data    = 16'($urandom);
            exf_is_load = ($urandom_range(0, 2) == 0);
            wb_wen      = ($urandom_range(0, 1) == 1);
            wb_adr      = 3'($urandom);
            wb_data     = 16'($urandom);
            ex_stall    = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            step();
        end

        idle();
        repeat (3) step();
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
